// File: rtl/scan_pkg.sv
// Shared types and constants for the scan sequencer and its timer.
package scan_pkg;

  // Sequencer phases: idle, blanking gap before a position, driving a position.
  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StDrive
  } state_e;

  // Decoder enable patterns, ordered {G1, G2A, G2B}.
  localparam logic [2:0] EN_ON  = 3'b100;
  localparam logic [2:0] EN_OFF = 3'b011;

  // Blanking cycles inserted before each drive phase (legal 1..15).
  localparam int unsigned BLANK_CYC_DEFAULT = 2;

  // True in the phases where the sequencer is actively scanning.
  function automatic logic is_busy(state_e s);
    return s != StIdle;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter shared by the blank and dwell phases.
// tc is high while the count sits at zero; a load takes priority over counting.
module scan_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  // Load on strobe, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Scan sequencer driving a 3-to-8 active-low decoder: select lines {C,B,A} and
// enables G1/G2A/G2B. Each position gets BLANK_CYC blanking cycles followed by
// max(dwell,1) drive cycles. One-shot or continuous sweeps over 0..last_idx.
// Build option: define SCAN_PINGPONG_EN for a bouncing order 0,1,..,L,L-1,..,1
// (a direction register is added); undefined gives the wrapping order 0..L.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int unsigned DWELL_W   = 16,
  parameter int unsigned BLANK_CYC = BLANK_CYC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [2:0]         last_idx,
  output logic               C,
  output logic               B,
  output logic               A,
  output logic               G1,
  output logic               G2A,
  output logic               G2B,
  output logic               busy,
  output logic               sweep_done
);

  // Timer must hold both the dwell reload and the blank reload (up to 14).
  localparam int unsigned TW = (DWELL_W > 4) ? DWELL_W : 4;

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] last_q, last_d;
  logic       armed_q, armed_d;
  logic       done_q, done_d;
  logic [2:0] en_pat_q, en_pat_d;
  logic       busy_q, busy_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_tc;
  logic [TW-1:0] blank_ld;
  logic [TW-1:0] dwell_ld;

  logic       sweep_end;
  logic [2:0] idx_step;
`ifdef SCAN_PINGPONG_EN
  logic dir_q, dir_d, dir_step;  // 0 = counting up, 1 = counting down
`endif

  assign blank_ld = TW'(BLANK_CYC - 1);

  // Dwell reload value; a dwell of 0 behaves as 1 cycle.
  always_comb begin
    dwell_ld = '0;
    if (dwell != '0) begin
      dwell_ld[DWELL_W-1:0] = dwell - DWELL_W'(1);
    end
  end

`ifdef SCAN_PINGPONG_EN
  // Next position in bouncing order and whether this drive closes the sweep.
  always_comb begin
    sweep_end = 1'b0;
    idx_step  = idx_q;
    dir_step  = dir_q;
    if (last_q == 3'd0) begin
      sweep_end = 1'b1;
    end else if (!dir_q) begin
      if (idx_q != last_q) begin
        idx_step = idx_q + 3'd1;
      end else if (last_q == 3'd1) begin
        sweep_end = 1'b1;
      end else begin
        dir_step = 1'b1;
        idx_step = idx_q - 3'd1;
      end
    end else begin
      if (idx_q > 3'd1) begin
        idx_step = idx_q - 3'd1;
      end else begin
        sweep_end = 1'b1;
      end
    end
  end
`else
  // Next position in wrapping order and whether this drive closes the sweep.
  always_comb begin
    sweep_end = (idx_q == last_q);
    idx_step  = idx_q + 3'd1;
  end
`endif

  // Next-state logic; dropping en aborts a sweep ahead of any completion.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    armed_d  = armed_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = blank_ld;
`ifdef SCAN_PINGPONG_EN
    dir_d    = dir_q;
`endif
    if (state_q != StIdle && !en) begin
      state_d = StIdle;
      idx_d   = 3'd0;
      armed_d = 1'b1;
`ifdef SCAN_PINGPONG_EN
      dir_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!en) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d  = StBlank;
            idx_d    = 3'd0;
            last_d   = last_idx;
            tmr_load = 1'b1;
          end
        end
        StBlank: begin
          if (tmr_tc) begin
            state_d  = StDrive;
            tmr_load = 1'b1;
            tmr_val  = dwell_ld;
          end
        end
        StDrive: begin
          if (tmr_tc) begin
            if (sweep_end) begin
              done_d = 1'b1;
              idx_d  = 3'd0;
`ifdef SCAN_PINGPONG_EN
              dir_d  = 1'b0;
`endif
              if (cont) begin
                state_d  = StBlank;
                last_d   = last_idx;
                tmr_load = 1'b1;
              end else begin
                state_d = StIdle;
                armed_d = 1'b0;
              end
            end else begin
              state_d  = StBlank;
              idx_d    = idx_step;
              tmr_load = 1'b1;
`ifdef SCAN_PINGPONG_EN
              dir_d    = dir_step;
`endif
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
    en_pat_d = (state_d == StDrive) ? EN_ON : EN_OFF;
    busy_d   = is_busy(state_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= 3'd0;
      last_q   <= 3'd0;
      armed_q  <= 1'b1;
      done_q   <= 1'b0;
      en_pat_q <= EN_OFF;
      busy_q   <= 1'b0;
`ifdef SCAN_PINGPONG_EN
      dir_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      armed_q  <= armed_d;
      done_q   <= done_d;
      en_pat_q <= en_pat_d;
      busy_q   <= busy_d;
`ifdef SCAN_PINGPONG_EN
      dir_q    <= dir_d;
`endif
    end
  end

  scan_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .tc      (tmr_tc)
  );

  assign {C, B, A}       = idx_q;
  assign {G1, G2A, G2B}  = en_pat_q;
  assign busy            = busy_q;
  assign sweep_done      = done_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: slot-timeline reference model compared every cycle,
// plus directed literal checks on sweep timing, abort and async reset.
module tb_scan_sequencer;

  localparam int unsigned DW = 16;
  localparam int BLANK = 2;
  localparam logic [7:0] VEC_IDLE = 8'b000_0_1_1_0_0;  // {CBA,G1,G2A,G2B,busy,done}

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          cont = 1'b0;
  logic [DW-1:0] dwell = 16'd1;
  logic [2:0]    last_idx = 3'd0;
  logic          C, B, A, G1, G2A, G2B, busy, sweep_done;
  logic [7:0]    dut_vec;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  scan_sequencer #(
    .DWELL_W  (DW),
    .BLANK_CYC(BLANK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cont      (cont),
    .dwell     (dwell),
    .last_idx  (last_idx),
    .C         (C),
    .B         (B),
    .A         (A),
    .G1        (G1),
    .G2A       (G2A),
    .G2B       (G2B),
    .busy      (busy),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  assign dut_vec = {C, B, A, G1, G2A, G2B, busy, sweep_done};

  // Model: each position is a slot of BLANK + dwell cycles; t is the offset in it.
  typedef struct packed {
    bit active;
    int pos;
    int t;
    int dlen;
    int lim;
    bit armed;
    bit done;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.active = 1'b0; m.pos = 0; m.t = 0; m.dlen = 1; m.lim = 0;
    m.armed = 1'b1; m.done = 1'b0;
    return m;
  endfunction

  function automatic model_t model_next(model_t m, bit e, bit c, int d, int li);
    model_t n = m;
    n.done = 1'b0;
    if (!m.active) begin
      if (e && m.armed) begin
        n.active = 1'b1; n.pos = 0; n.t = 0; n.lim = li;
      end else if (!e) begin
        n.armed = 1'b1;
      end
    end else if (!e) begin
      n.active = 1'b0; n.pos = 0; n.t = 0; n.armed = 1'b1;
    end else begin
      if (m.t == BLANK - 1) n.dlen = (d == 0) ? 1 : d;
      if (m.t >= BLANK && m.t == BLANK + m.dlen - 1) begin
        n.t = 0;
        if (m.pos < m.lim) begin
          n.pos = m.pos + 1;
        end else begin
          n.done = 1'b1;
          n.pos = 0;
          if (c) n.lim = li;
          else begin
            n.active = 1'b0; n.armed = 1'b0;
          end
        end
      end else begin
        n.t = m.t + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] model_out(model_t m);
    bit drive;
    drive = m.active && (m.t >= BLANK);
    return {3'(m.pos), drive, !drive, !drive, m.active, m.done};
  endfunction

  model_t mdl = model_reset();

  always @(posedge clk or posedge rst) begin
    if (rst) mdl <= model_reset();
    else mdl <= model_next(mdl, en, cont, int'(dwell), int'(last_idx));
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst && chk_on) begin
      n_cmp++;
      if (dut_vec !== model_out(mdl)) begin
        n_bad++;
        $display("FAIL cycle_compare @%0t: dut=%b model=%b (CBA,G1,G2A,G2B,busy,done)",
                 $time, dut_vec, model_out(mdl));
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, np, g1c, blk, dcnt, dat, fd2;
    int drv[8];
    int pt[3];
    int tbl_d[8];
    int tbl_l[8];
    bit found;

    // Reset state.
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_vector", int'(dut_vec), int'(VEC_IDLE));
    rst = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);

    // One-shot sweep L=2, dwell=3: 0,1,2 each 2 blank + 3 drive.
    en = 1'b1; cont = 1'b0; last_idx = 3'd2; dwell = 16'd3;
    k = 0;
    while (!busy && k < 5) begin
      @(negedge clk);
      k++;
    end
    check("t1_start_latency", k, 1);
    for (int i = 0; i < 8; i++) drv[i] = 0;
    blk = 0; dcnt = 0; dat = -1; fd2 = -1;
    for (int w = 0; w < 30; w++) begin
      if (sweep_done) begin
        dcnt++;
        if (dat < 0) dat = w;
      end
      if (G1) begin
        drv[{C, B, A}]++;
        if ({C, B, A} == 3'd2 && fd2 < 0) fd2 = w;
      end
      if (busy && !G1) blk++;
      @(negedge clk);
    end
    check("t1_done_at", dat, 15);
    check("t1_done_count", dcnt, 1);
    check("t1_drive_pos0", drv[0], 3);
    check("t1_drive_pos1", drv[1], 3);
    check("t1_drive_pos2", drv[2], 3);
    check("t1_blank_cycles", blk, 6);
    check("t1_first_drive_pos2", fd2, 12);
    check("t1_no_restart_busy", int'(busy), 0);

    // Continuous L=7, dwell=1: period 8 * (2 + 1) = 24.
    en = 1'b0;
    @(negedge clk);
    cont = 1'b1; last_idx = 3'd7; dwell = 16'd1; en = 1'b1;
    np = 0;
    for (int w = 0; w < 90; w++) begin
      if (sweep_done && np < 3) begin
        pt[np] = w;
        np++;
      end
      @(negedge clk);
    end
    check("t2_pulse_count", np, 3);
    if (np == 3) begin
      check("t2_period_a", pt[1] - pt[0], 24);
      check("t2_period_b", pt[2] - pt[1], 24);
    end

    // Abort during DRIVE of position 4.
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      if (G1 && {C, B, A} == 3'd4) found = 1'b1;
      else @(negedge clk);
    end
    check("t3_found_pos4_drive", int'(found), 1);
    en = 1'b0;
    @(negedge clk);
    check("t3_abort_vector", int'(dut_vec), int'(VEC_IDLE));
    en = 1'b1;
    @(negedge clk);
    check("t3_restart_vector", int'(dut_vec), int'(8'b000_0_1_1_1_0));

    // dwell=0, L=0, continuous: one drive cycle, period 3.
    en = 1'b0;
    @(negedge clk);
    dwell = 16'd0; last_idx = 3'd0; cont = 1'b1; en = 1'b1;
    np = 0; g1c = 0;
    for (int w = 0; w < 40; w++) begin
      if (sweep_done && np < 3) begin
        pt[np] = w;
        np++;
      end
      if (np == 1 && G1) g1c++;
      @(negedge clk);
    end
    check("t4_pulse_count", np, 3);
    if (np == 3) check("t4_period", pt[1] - pt[0], 3);
    check("t4_drive_per_sweep", g1c, 1);

    // Mid-sweep changes to dwell/last_idx; only the model judges these.
    tbl_d = '{2, 5, 0, 1, 4, 3, 7, 2};
    tbl_l = '{5, 1, 3, 0, 7, 2, 4, 6};
    en = 1'b0;
    @(negedge clk);
    cont = 1'b1; last_idx = 3'd5; dwell = 16'd2; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (7) @(negedge clk);
      dwell = 16'(tbl_d[i]);
      last_idx = 3'(tbl_l[i]);
    end
    repeat (10) @(negedge clk);

    // One-shot re-arm: en must go low before a second sweep.
    en = 1'b0;
    @(negedge clk);
    cont = 1'b0; last_idx = 3'd1; dwell = 16'd2; en = 1'b1;
    np = 0;
    for (int w = 0; w < 15; w++) begin
      if (sweep_done) np++;
      @(negedge clk);
    end
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    for (int w = 0; w < 15; w++) begin
      if (sweep_done) np++;
      @(negedge clk);
    end
    check("t6_oneshot_pulses", np, 2);

    // Async reset between clock edges during DRIVE.
    en = 1'b0;
    @(negedge clk);
    cont = 1'b1; last_idx = 3'd3; dwell = 16'd4; en = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      if (G1) found = 1'b1;
      else @(negedge clk);
    end
    check("t7_found_drive", int'(found), 1);
    #2;
    check("t7_pre_reset_g1", int'(G1), 1);
    rst = 1'b1;
    #1;
    check("t7_async_reset_vector", int'(dut_vec), int'(VEC_IDLE));
    repeat (2) @(negedge clk);
    en = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
